ctrl_pipe_unit: RTL and testbench
=================================

// Module: ctrl_pipe_unit
// PURPOSE
//  Pipelined successor to the WISC decode control logic. Decodes {opcode[4:0],func[1:0]} in ID, then
//  carries the control bundle through EX/MEM/WB registers with valid bits, stall/flush handling,
//  load-use hazard detection, sticky halt and a one-cycle exception pulse. Sits between fetch/decode
//  and the datapath; the datapath reads each stage's control bundle directly.
// PARAMETERS
//  REG_AW     3  register-specifier width (8 GPRs)
//  HAZARD_EN  1  1: load-use interlock active; 0: id_stall tied 0 (compiler-scheduled code)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       synchronous reset, active-low
//  id_valid   in   1       ID holds a real instruction
//  id_opcode  in   5       instruction opcode
//  id_func    in   2       R-format function field
//  id_rs      in   REG_AW  source reg 1;  id_rs_use in 1: instruction reads rs
//  id_rt      in   REG_AW  source reg 2;  id_rt_use in 1: instruction reads rt
//  id_wreg    in   REG_AW  destination register (already muxed by decode)
//  flush      in   1       taken branch/jump resolved in EX: kill ID and EX slots
//  ext_stall  in   1       memory not ready: freeze whole pipe
//  id_stall   out  1       freeze PC and IF/ID (load-use hazard)
//  ex_valid   out  1       ex_ctrl  out CTRL_W  EX bundle (aluop,alusrc,invA,invB,cin,set,btr,zeroext,branch,jump,jumpreg)
//  mem_valid  out  1       mem_ctrl out CTRL_W  MEM bundle (memread,memwrite)
//  wb_valid   out  1       wb_ctrl  out CTRL_W  WB bundle (regwrite,memtoreg); wb_wreg out REG_AW
//  halted     out  1       sticky: HALT retired
//  excp_pulse out  1       one-cycle pulse: SIIC retired
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all valids, bundles, wb_wreg, halted, excp_pulse, halt_seen <= 0.
//  - Decode is combinational from isa_pkg table; bundle registered into EX at posedge when
//    id_valid & ~id_stall & ~ext_stall & ~flush & ~halt_seen. Latency ID->EX 1, ->MEM 2, ->WB 3.
//  - Every stage's *_ctrl is forced to 0 when its valid is 0 (bubbles carry no side effects).
//  - Priority per cycle: rst_n > ext_stall > flush > hazard > advance.
//  - ext_stall=1: all stage registers hold; id_stall reflects hazard but has no extra effect.
//  - flush=1 (ext_stall=0): ex_valid<=0, ID not captured, id_stall=0; MEM/WB advance normally
//    (older instruction in EX moves to MEM before kill is applied; only ID/EX contents die).
//  - Hazard (HAZARD_EN=1): id_stall = id_valid & ex_valid & ex memread & ((id_rs_use & id_rs==ex_wreg)
//    | (id_rt_use & id_rt==ex_wreg)). When set: EX <= bubble, MEM/WB advance, ID held (1 bubble).
//  - halt_seen set when HALT (00000) enters EX; further ID instructions are dropped (never valid).
//    halted <= 1 when HALT reaches WB with wb_valid; holds until reset. Flushed HALT clears nothing
//    and does not set halt_seen-> halt_seen is cleared if the EX HALT is flushed.
//  - excp_pulse = 1 for exactly the cycle SIIC (00010) occupies WB valid; not repeated under ext_stall.
//  - NOP (00001): valid, all control 0, no halt/excp. Undefined opcodes decode as NOP.
//  - RTL is fully synchronous; no latches; decode always @* with default assignment.
// STRUCTURE
//  - isa_pkg (shared): opcode localparams, ALUOP_* codes (ROL 000,SLL 001,ROR 010,SRL 011,ADD 100,
//    OR 101,XOR 110,AND 111), CTRL_W and bundle field offsets.
//  - Sub-module ctrl_decode: pure combinational {opcode,func} -> bundle; reused by the bench model.
//  - Top: three stage registers + hazard compare + halt/excp logic.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles mid-stream with ADD in all stages -> all valids 0, halted 0 next edge.
//  2 Stream ADDI(01000), ADD(11011,f=00), ST(10000) -> ex aluop=100 alusrc=1; mem memwrite=1 at cycle 3
//    for ST; wb regwrite=1 for ADDI at t+3, 0 for ST.
//  3 LD r2 (10001) then ADD rs=r2 -> id_stall=1 one cycle, EX bubble (ex_valid=0), ADD reaches WB 5 cycles after LD issued.
//  4 flush=1 with SUB in EX and BEQZ in MEM -> ex_valid=0 next cycle, BEQZ continues to WB; flush+hazard same cycle -> id_stall=0.
//  5 ext_stall=1 for 3 cycles -> all *_valid/*_ctrl unchanged; SIIC in WB yields single excp_pulse.
//  6 HALT then ADD,ADD -> ADDs never valid in EX; halted=1 3 cycles after HALT captured, stays 1.

Source files
------------

// File: rtl/ctrl_pipe_unit_pkg.sv
// ISA encodings, ALU op codes and the control bundle
// shared by the decode and pipeline control logic.
package ctrl_pipe_unit_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_SIIC  = 5'b00010;
  localparam logic [4:0] OP_RTI   = 5'b00011;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_ROLI  = 5'b10100;
  localparam logic [4:0] OP_SLLI  = 5'b10101;
  localparam logic [4:0] OP_RORI  = 5'b10110;
  localparam logic [4:0] OP_SRLI  = 5'b10111;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_SHF   = 5'b11010;
  localparam logic [4:0] OP_ARI   = 5'b11011;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SLT   = 5'b11101;
  localparam logic [4:0] OP_SLE   = 5'b11110;
  localparam logic [4:0] OP_SCO   = 5'b11111;

  localparam logic [2:0] ALUOP_ROL = 3'b000;
  localparam logic [2:0] ALUOP_SLL = 3'b001;
  localparam logic [2:0] ALUOP_ROR = 3'b010;
  localparam logic [2:0] ALUOP_SRL = 3'b011;
  localparam logic [2:0] ALUOP_ADD = 3'b100;
  localparam logic [2:0] ALUOP_OR  = 3'b101;
  localparam logic [2:0] ALUOP_XOR = 3'b110;
  localparam logic [2:0] ALUOP_AND = 3'b111;

  typedef struct packed {
    logic       halt;
    logic       excp;
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       jumpreg;
    logic       jump;
    logic       branch;
    logic       zeroext;
    logic       btr;
    logic       set;
    logic       cin;
    logic       invb;
    logic       inva;
    logic       alusrc;
    logic [2:0] aluop;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam int B_ALUOP    = 0;
  localparam int B_ALUSRC   = 3;
  localparam int B_INVA     = 4;
  localparam int B_INVB     = 5;
  localparam int B_CIN      = 6;
  localparam int B_SET      = 7;
  localparam int B_BTR      = 8;
  localparam int B_ZEROEXT  = 9;
  localparam int B_BRANCH   = 10;
  localparam int B_JUMP     = 11;
  localparam int B_JUMPREG  = 12;
  localparam int B_MEMWRITE = 13;
  localparam int B_MEMREAD  = 14;
  localparam int B_MEMTOREG = 15;
  localparam int B_REGWRITE = 16;
  localparam int B_EXCP     = 17;
  localparam int B_HALT     = 18;

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// Combinational {opcode,func} -> control bundle.
// Ports: opcode, func in; ctrl (ctrl_t) out.
module ctrl_pipe_unit_decode
  import ctrl_pipe_unit_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [1:0] func,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_HALT: ctrl.halt = 1'b1;
      OP_SIIC: ctrl.excp = 1'b1;
      OP_ADDI: begin
        ctrl.aluop    = ALUOP_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_SUBI: begin
        ctrl.aluop    = ALUOP_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.inva     = 1'b1;
        ctrl.cin      = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_XORI: begin
        ctrl.aluop    = ALUOP_XOR;
        ctrl.alusrc   = 1'b1;
        ctrl.zeroext  = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_ANDNI: begin
        ctrl.aluop    = ALUOP_AND;
        ctrl.alusrc   = 1'b1;
        ctrl.invb     = 1'b1;
        ctrl.zeroext  = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
        // low opcode bits line up with the shift aluop codes
        ctrl.aluop    = {1'b0, opcode[1:0]};
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_ST: begin
        ctrl.aluop    = ALUOP_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      OP_LD: begin
        ctrl.aluop    = ALUOP_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_STU: begin
        ctrl.aluop    = ALUOP_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_LBI: begin
        ctrl.aluop    = ALUOP_OR;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_SLBI: begin
        ctrl.aluop    = ALUOP_OR;
        ctrl.alusrc   = 1'b1;
        ctrl.zeroext  = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_BTR: begin
        ctrl.btr      = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_SHF: begin
        ctrl.aluop    = {1'b0, func};
        ctrl.regwrite = 1'b1;
      end
      OP_ARI: begin
        ctrl.regwrite = 1'b1;
        unique case (func)
          2'b00: ctrl.aluop = ALUOP_ADD;
          2'b01: begin
            ctrl.aluop = ALUOP_ADD;
            ctrl.inva  = 1'b1;
            ctrl.cin   = 1'b1;
          end
          2'b10: ctrl.aluop = ALUOP_XOR;
          2'b11: begin
            ctrl.aluop = ALUOP_AND;
            ctrl.invb  = 1'b1;
          end
          default: ctrl.aluop = ALUOP_ADD;
        endcase
      end
      OP_SEQ, OP_SLT, OP_SLE: begin
        // compares evaluate rs - rt
        ctrl.aluop    = ALUOP_ADD;
        ctrl.invb     = 1'b1;
        ctrl.cin      = 1'b1;
        ctrl.set      = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_SCO: begin
        ctrl.aluop    = ALUOP_ADD;
        ctrl.set      = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ:
        ctrl.branch = 1'b1;
      OP_J: ctrl.jump = 1'b1;
      OP_JR: begin
        ctrl.aluop   = ALUOP_ADD;
        ctrl.alusrc  = 1'b1;
        ctrl.jump    = 1'b1;
        ctrl.jumpreg = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_JALR: begin
        ctrl.aluop    = ALUOP_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.jump     = 1'b1;
        ctrl.jumpreg  = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control: ID decode, EX/MEM/WB bundles with valids,
// flush, external stall, load-use interlock, sticky halt, exception pulse.
// In: clk, rst_n, id_* instruction fields, flush, ext_stall.
// Out: id_stall, {ex,mem,wb}_valid/_ctrl, wb_wreg, halted, excp_pulse.
module ctrl_pipe_unit
  import ctrl_pipe_unit_pkg::*;
#(
  parameter int unsigned REG_AW    = 3,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_opcode,
  input  logic [1:0]        id_func,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_use,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_use,
  input  logic [REG_AW-1:0] id_wreg,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              mem_valid,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [REG_AW-1:0] wb_wreg,
  output logic              halted,
  output logic              excp_pulse
);

  ctrl_t dec;
  ctrl_t ex_q, mem_q, wb_q;
  logic  ex_v, mem_v, wb_v;
  logic [REG_AW-1:0] ex_wreg_q, mem_wreg_q, wb_wreg_q;
  logic  halt_seen_q, halted_q, excp_q;
  logic  rs_hit, rt_hit, hazard, capture;

  ctrl_pipe_unit_decode u_dec (
    .opcode (id_opcode),
    .func   (id_func),
    .ctrl   (dec)
  );

  assign rs_hit = id_rs_use & (id_rs == ex_wreg_q);
  assign rt_hit = id_rt_use & (id_rt == ex_wreg_q);
  assign hazard = HAZARD_EN & id_valid & ex_v
                & ex_q.memread & (rs_hit | rt_hit);

  // a flush kills the waiting instruction, so no reason to hold it
  assign id_stall = hazard & ~flush;
  assign capture  = id_valid & ~hazard & ~flush & ~halt_seen_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_v        <= 1'b0;
      mem_v       <= 1'b0;
      wb_v        <= 1'b0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_wreg_q   <= '0;
      mem_wreg_q  <= '0;
      wb_wreg_q   <= '0;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
      excp_q      <= 1'b0;
    end else begin
      if (wb_v & wb_q.halt)
        halted_q <= 1'b1;
      // pulse only on the edge SIIC moves into WB
      excp_q <= ~ext_stall & mem_v & mem_q.excp;
      if (!ext_stall) begin
        wb_v       <= mem_v;
        wb_q       <= mem_q;
        wb_wreg_q  <= mem_wreg_q;
        mem_v      <= ex_v;
        mem_q      <= ex_q;
        mem_wreg_q <= ex_wreg_q;
        ex_v       <= capture;
        ex_q       <= capture ? dec : '0;
        ex_wreg_q  <= capture ? id_wreg : '0;
        if (capture & dec.halt)
          halt_seen_q <= 1'b1;
        else if (flush & ex_v & ex_q.halt)
          halt_seen_q <= 1'b0;
      end
    end
  end

  assign ex_valid   = ex_v;
  assign ex_ctrl    = ex_q;
  assign mem_valid  = mem_v;
  assign mem_ctrl   = mem_q;
  assign wb_valid   = wb_v;
  assign wb_ctrl    = wb_q;
  assign wb_wreg    = wb_wreg_q;
  assign halted     = halted_q;
  assign excp_pulse = excp_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit with a WB scoreboard.
// Expected bundles come from a local table of the opcodes exercised.
module tb_ctrl_pipe_unit;
  import ctrl_pipe_unit_pkg::*;

  localparam int RA = 3;
  typedef logic [CTRL_W+RA-1:0] sb_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid;
  logic [4:0] id_opcode;
  logic [1:0] id_func;
  logic [RA-1:0] id_rs, id_rt, id_wreg;
  logic id_rs_use, id_rt_use;
  logic flush, ext_stall;
  logic id_stall;
  logic ex_valid, mem_valid, wb_valid;
  logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [RA-1:0] wb_wreg;
  logic halted, excp_pulse;

  int n_cmp = 0;
  int n_err = 0;
  sb_t q[$];

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.REG_AW(RA), .HAZARD_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .id_func    (id_func),
    .id_rs      (id_rs),
    .id_rs_use  (id_rs_use),
    .id_rt      (id_rt),
    .id_rt_use  (id_rt_use),
    .id_wreg    (id_wreg),
    .flush      (flush),
    .ext_stall  (ext_stall),
    .id_stall   (id_stall),
    .ex_valid   (ex_valid),
    .ex_ctrl    (ex_ctrl),
    .mem_valid  (mem_valid),
    .mem_ctrl   (mem_ctrl),
    .wb_valid   (wb_valid),
    .wb_ctrl    (wb_ctrl),
    .wb_wreg    (wb_wreg),
    .halted     (halted),
    .excp_pulse (excp_pulse)
  );

  function automatic logic [CTRL_W-1:0] ev(
    input logic [4:0] op, input logic [1:0] fn);
    logic [CTRL_W-1:0] v;
    v = '0;
    case (op)
      5'b00000: v[B_HALT] = 1'b1;
      5'b00010: v[B_EXCP] = 1'b1;
      5'b01000: begin
        v[B_ALUOP +: 3] = 3'b100;
        v[B_ALUSRC]     = 1'b1;
        v[B_REGWRITE]   = 1'b1;
      end
      5'b11011: begin
        v[B_ALUOP +: 3] = 3'b100;
        v[B_REGWRITE]   = 1'b1;
        if (fn == 2'b01) begin
          v[B_INVA] = 1'b1;
          v[B_CIN]  = 1'b1;
        end
      end
      5'b10000: begin
        v[B_ALUOP +: 3] = 3'b100;
        v[B_ALUSRC]     = 1'b1;
        v[B_MEMWRITE]   = 1'b1;
      end
      5'b10001: begin
        v[B_ALUOP +: 3] = 3'b100;
        v[B_ALUSRC]     = 1'b1;
        v[B_MEMREAD]    = 1'b1;
        v[B_MEMTOREG]   = 1'b1;
        v[B_REGWRITE]   = 1'b1;
      end
      5'b01100: v[B_BRANCH] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op,
                       input logic [1:0] fn,
                       input logic [RA-1:0] wr,
                       input logic [RA-1:0] rs,
                       input logic [RA-1:0] rt,
                       input logic rsu,
                       input logic rtu);
    id_valid  = 1'b1;
    id_opcode = op;
    id_func   = fn;
    id_wreg   = wr;
    id_rs     = rs;
    id_rt     = rt;
    id_rs_use = rsu;
    id_rt_use = rtu;
  endtask

  task automatic push(input logic [4:0] op,
                      input logic [1:0] fn,
                      input logic [RA-1:0] wr);
    q.push_back({ev(op, fn), wr});
  endtask

  task automatic idle();
    id_valid  = 1'b0;
    id_rs_use = 1'b0;
    id_rt_use = 1'b0;
  endtask

  task automatic step();
    bit live;
    live = rst_n && !ext_stall;
    @(posedge clk);
    #1;
    if (live && wb_valid) begin
      if (q.size() == 0)
        check("sb_extra", {31'd0, wb_valid}, 32'd0);
      else
        check("sb_wb", {wb_ctrl, wb_wreg}, q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ext_stall = 1'b0;
    id_opcode = '0;
    id_func = '0;
    id_rs = '0;
    id_rt = '0;
    id_wreg = '0;
    idle();
    step();
    step();
    check("rst_valids", {ex_valid, mem_valid, wb_valid}, 0);
    check("rst_ctrl", {ex_ctrl, mem_ctrl}, 0);
    check("rst_wb", {wb_ctrl, wb_wreg}, 0);
    check("rst_flags", {halted, excp_pulse, id_stall}, 0);
    rst_n = 1'b1;

    // ADDI, ADD, ST stream
    drive(5'b01000, 2'b00, 3'd1, 3'd0, 3'd0, 1, 0);
    push(5'b01000, 2'b00, 3'd1);
    step();
    check("addi_ex_valid", ex_valid, 1);
    check("addi_aluop", ex_ctrl[B_ALUOP +: 3], 3'b100);
    check("addi_alusrc", ex_ctrl[B_ALUSRC], 1);
    drive(5'b11011, 2'b00, 3'd3, 3'd1, 3'd2, 1, 1);
    push(5'b11011, 2'b00, 3'd3);
    step();
    check("add_ex_ctrl", ex_ctrl, ev(5'b11011, 2'b00));
    drive(5'b10000, 2'b00, 3'd0, 3'd1, 3'd3, 1, 1);
    push(5'b10000, 2'b00, 3'd0);
    step();
    check("addi_wb_rw", {wb_valid, wb_ctrl[B_REGWRITE]}, 2'b11);
    idle();
    step();
    check("st_mem_wr", {mem_valid, mem_ctrl[B_MEMWRITE]}, 2'b11);
    step();
    check("st_wb_rw", {wb_valid, wb_ctrl[B_REGWRITE]}, 2'b10);
    step();

    // load-use: LD r2 then ADD rs=r2
    drive(5'b10001, 2'b00, 3'd2, 3'd4, 3'd0, 1, 0);
    push(5'b10001, 2'b00, 3'd2);
    step();
    drive(5'b11011, 2'b00, 3'd6, 3'd2, 3'd5, 1, 1);
    #1;
    check("lu_stall", id_stall, 1);
    step();
    check("lu_bubble", ex_valid, 0);
    check("lu_release", id_stall, 0);
    push(5'b11011, 2'b00, 3'd6);
    step();
    check("lu_add_ex", ex_valid, 1);
    idle();
    step();
    check("lu_wb_bubble", wb_valid, 0);
    step();
    check("lu_add_wb", {wb_valid, wb_wreg}, {1'b1, 3'd6});
    step();

    // flush with SUB in EX, BEQZ in MEM
    drive(5'b01100, 2'b00, 3'd0, 3'd1, 3'd0, 1, 0);
    push(5'b01100, 2'b00, 3'd0);
    step();
    drive(5'b11011, 2'b01, 3'd4, 3'd1, 3'd2, 1, 1);
    push(5'b11011, 2'b01, 3'd4);
    step();
    check("sub_ex_ctrl", ex_ctrl, ev(5'b11011, 2'b01));
    check("beqz_mem", mem_ctrl[B_BRANCH], 1);
    flush = 1'b1;
    drive(5'b11011, 2'b00, 3'd5, 3'd1, 3'd2, 1, 1);
    step();
    check("fl_ex_dead", {ex_valid, ex_ctrl}, 0);
    check("fl_sub_mem", mem_ctrl, ev(5'b11011, 2'b01));
    check("fl_beqz_wb", {wb_valid, wb_ctrl[B_BRANCH]}, 2'b11);
    flush = 1'b0;
    idle();
    step();
    step();
    step();

    // flush and hazard together
    drive(5'b10001, 2'b00, 3'd3, 3'd1, 3'd0, 1, 0);
    push(5'b10001, 2'b00, 3'd3);
    step();
    drive(5'b11011, 2'b00, 3'd6, 3'd3, 3'd0, 1, 0);
    #1;
    check("fh_hazard", id_stall, 1);
    flush = 1'b1;
    #1;
    check("fh_no_stall", id_stall, 0);
    step();
    check("fh_ex_dead", ex_valid, 0);
    flush = 1'b0;
    idle();
    step();
    step();
    step();

    // ext_stall with SIIC in WB
    drive(5'b00010, 2'b00, 3'd0, 3'd0, 3'd0, 0, 0);
    push(5'b00010, 2'b00, 3'd0);
    step();
    drive(5'b01000, 2'b00, 3'd4, 3'd0, 3'd0, 1, 0);
    push(5'b01000, 2'b00, 3'd4);
    step();
    drive(5'b11011, 2'b00, 3'd5, 3'd1, 3'd2, 1, 1);
    push(5'b11011, 2'b00, 3'd5);
    step();
    check("siic_pulse", excp_pulse, 1);
    ext_stall = 1'b1;
    drive(5'b00001, 2'b00, 3'd0, 3'd0, 3'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_ex", {ex_valid, ex_ctrl},
            {1'b1, ev(5'b11011, 2'b00)});
      check("st_mem", {mem_valid, mem_ctrl},
            {1'b1, ev(5'b01000, 2'b00)});
      check("st_wb", {wb_valid, wb_ctrl},
            {1'b1, ev(5'b00010, 2'b00)});
      check("st_pulse", excp_pulse, 0);
    end
    ext_stall = 1'b0;
    idle();
    step();
    check("post_st_pulse", excp_pulse, 0);
    step();
    step();
    step();

    // mid-stream reset with ADD in every stage
    drive(5'b11011, 2'b00, 3'd1, 3'd0, 3'd0, 1, 0);
    push(5'b11011, 2'b00, 3'd1);
    step();
    push(5'b11011, 2'b00, 3'd1);
    step();
    push(5'b11011, 2'b00, 3'd1);
    step();
    check("full_pipe", {ex_valid, mem_valid, wb_valid}, 3'b111);
    rst_n = 1'b0;
    step();
    step();
    check("mrst_valids", {ex_valid, mem_valid, wb_valid}, 0);
    check("mrst_flags", {halted, excp_pulse}, 0);
    check("mrst_wb", {wb_ctrl, wb_wreg}, 0);
    q.delete();
    idle();
    rst_n = 1'b1;
    step();

    // HALT then ADD, ADD
    drive(5'b00000, 2'b00, 3'd0, 3'd0, 3'd0, 0, 0);
    push(5'b00000, 2'b00, 3'd0);
    step();
    check("halt_ex", {ex_valid, ex_ctrl[B_HALT]}, 2'b11);
    drive(5'b11011, 2'b00, 3'd2, 3'd1, 3'd1, 1, 1);
    step();
    check("halt_drop1", ex_valid, 0);
    step();
    check("halt_drop2", ex_valid, 0);
    check("halted_early", halted, 0);
    step();
    check("halted_set", halted, 1);
    step();
    check("halted_hold", {halted, ex_valid}, 2'b10);
    idle();
    step();
    check("halted_sticky", halted, 1);
    check("sb_left", q.size(), 0);
    rst_n = 1'b0;
    step();
    check("halt_rst", halted, 0);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
